// File: rtl/wb_fifo_pkg.sv
// ----------------------------------------------------------------------------
// wb_fifo_pkg
//   Shared constants and helpers for the level-aware Wishbone FIFO:
//   default parameter values, depth / level-width helpers, reset values and
//   the packed status-flag bundle used inside the top.
//   No ports (package).
// ----------------------------------------------------------------------------
package wb_fifo_pkg;

    // Default configuration of the FIFO
    localparam int unsigned DW_DEFAULT         = 8;
    localparam int unsigned AW_DEFAULT         = 5;
    localparam int unsigned AFULL_THR_DEFAULT  = 24;
    localparam int unsigned AEMPTY_THR_DEFAULT = 4;

    // Reset values of registered control outputs
    localparam logic RST_ACK = 1'b0;
    localparam logic RST_ERR = 1'b0;

    // Number of storage entries for a given address width
    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

    // Level counter width: one extra bit so DEPTH itself is representable
    function automatic int unsigned fifo_lw(input int unsigned aw);
        return aw + 32'd1;
    endfunction

    // Occupancy flags derived from the registered level
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage : wb_fifo_pkg

// File: rtl/fifo_dpram.sv
// ----------------------------------------------------------------------------
// fifo_dpram
//   Simple dual-port RAM: one synchronous write port, one registered read
//   port. Storage has no reset; only the read-data register is reset so the
//   dequeued-word output starts at zero.
//   Ports:
//     clk, rst_n          clock / async active-low reset (read register only)
//     wr_en, wr_addr,
//     wr_data             write port
//     rd_en, rd_addr      read request; data appears on rd_data next cycle
//     rd_data             registered read data (holds between reads)
// ----------------------------------------------------------------------------
module fifo_dpram
    import wb_fifo_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned DEPTH = fifo_depth(AW);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    // Storage write port (no reset on the array)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read register captures only on a read, otherwise holds
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : fifo_dpram

// File: rtl/wb_fifo_lvl.sv
// ----------------------------------------------------------------------------
// wb_fifo_lvl
//   Level-aware Wishbone FIFO with its own dual-port storage. All 2**AW
//   entries are usable because occupancy is counted explicitly. A push and a
//   pop may complete in the same cycle; fill level plus almost-full /
//   almost-empty flags are reported.
//   Optional build macro: FIFO_ERR_FLAGS_EN enables sticky overflow /
//   underflow flags cleared by i_err_clr; without it those outputs are 0.
//   Ports:
//     i_clk, i_reset_n                     clock, async active-low reset
//     i_wb_push_data/stb/cyc               push request, o_wb_push_stall/ack
//     i_wb_pop_stb/cyc                     pop request, o_wb_pop_data/stall/ack
//     o_full, o_empty, o_almost_full,
//     o_almost_empty, o_level              occupancy status
//     i_err_clr, o_overflow, o_underflow   sticky error flags (optional)
// ----------------------------------------------------------------------------
module wb_fifo_lvl
    import wb_fifo_pkg::*;
#(
    parameter int unsigned DW         = DW_DEFAULT,
    parameter int unsigned AW         = AW_DEFAULT,
    parameter int unsigned AFULL_THR  = AFULL_THR_DEFAULT,
    parameter int unsigned AEMPTY_THR = AEMPTY_THR_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic [DW-1:0] i_wb_push_data,
    input  logic          i_wb_push_stb,
    input  logic          i_wb_push_cyc,
    output logic          o_wb_push_stall,
    output logic          o_wb_push_ack,
    input  logic          i_wb_pop_stb,
    input  logic          i_wb_pop_cyc,
    output logic [DW-1:0] o_wb_pop_data,
    output logic          o_wb_pop_stall,
    output logic          o_wb_pop_ack,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_almost_full,
    output logic          o_almost_empty,
    output logic [AW:0]   o_level,
    input  logic          i_err_clr,
    output logic          o_overflow,
    output logic          o_underflow
);

    localparam int unsigned DEPTH = fifo_depth(AW);
    localparam int unsigned LW    = fifo_lw(AW);

    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0] level_q,    level_d;
    logic          push_ack_q, push_ack_d;
    logic          pop_ack_q,  pop_ack_d;

    logic          push_req_c, pop_req_c;
    logic          push_ok_c,  pop_ok_c;
    fifo_flags_t   flags_c;

    // Status flags straight from the registered level
    always_comb begin
        flags_c              = '0;
        flags_c.full         = (level_q == LW'(DEPTH));
        flags_c.empty        = (level_q == '0);
        flags_c.almost_full  = (level_q >= LW'(AFULL_THR));
        flags_c.almost_empty = (level_q <= LW'(AEMPTY_THR));
    end

    // Request qualification, pointer / level update and ack generation.
    // Full blocks push and empty blocks pop, so a same-cycle push+pop never
    // touches the same address.
    always_comb begin
        push_req_c = i_wb_push_stb & i_wb_push_cyc;
        pop_req_c  = i_wb_pop_stb  & i_wb_pop_cyc;
        push_ok_c  = push_req_c & ~flags_c.full;
        pop_ok_c   = pop_req_c  & ~flags_c.empty;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        push_ack_d = push_ok_c;
        pop_ack_d  = pop_ok_c;

        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_ok_c, pop_ok_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            push_ack_q <= RST_ACK;
            pop_ack_q  <= RST_ACK;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            push_ack_q <= push_ack_d;
            pop_ack_q  <= pop_ack_d;
        end
    end

    // Storage; its read register doubles as the pop-data output register
    fifo_dpram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .wr_en   (push_ok_c),
        .wr_addr (wr_ptr_q),
        .wr_data (i_wb_push_data),
        .rd_en   (pop_ok_c),
        .rd_addr (rd_ptr_q),
        .rd_data (o_wb_pop_data)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; a new error in the clear cycle wins
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (i_err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push_req_c & flags_c.full) begin
            overflow_d = 1'b1;
        end
        if (pop_req_c & flags_c.empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            overflow_q  <= RST_ERR;
            underflow_q <= RST_ERR;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = i_err_clr;
    assign o_overflow     = RST_ERR;
    assign o_underflow    = RST_ERR;
`endif

    assign o_wb_push_ack   = push_ack_q;
    assign o_wb_pop_ack    = pop_ack_q;
    assign o_full          = flags_c.full;
    assign o_empty         = flags_c.empty;
    assign o_almost_full   = flags_c.almost_full;
    assign o_almost_empty  = flags_c.almost_empty;
    assign o_wb_push_stall = flags_c.full;
    assign o_wb_pop_stall  = flags_c.empty;
    assign o_level         = level_q;

endmodule : wb_fifo_lvl
